// File: rtl/rsa_feed_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_feed_pkg : shared types and helpers for the RSA operand feeder
// Rev 1.0
// ----------------------------------------------------------------------------
package rsa_feed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2,
    START  = 2'd3
  } feed_state_t;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  function automatic int max_depth(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_opnd_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_opnd_buf : append-only operand register file with fill count and full flag
// Rev 1.0
// ----------------------------------------------------------------------------
module rsa_opnd_buf #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_clr,
  input  logic             i_rd_en,
  input  logic [CNT_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_wr_ok;

  assign o_full    = (r_cnt == c_depth);
  assign w_wr_ok   = i_wr_en && !o_full;
  assign o_rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_wr_ok) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Storage is not reset: a word is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_cnt] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= i_rd_en ? r_mem[i_rd_addr] : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rsa_operand_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_operand_feeder : buffers X/Y operands and streams them into the RSA array
// Rev 1.0
// ----------------------------------------------------------------------------
module rsa_operand_feeder
  import rsa_feed_pkg::*;
#(
  parameter int X       = 3,
  parameter int N       = 4,
  parameter int Y       = 3,
  parameter int IN_LEN  = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              ld_val,
  input  logic              ld_sel,
  input  logic [IN_LEN-1:0] ld_data,
  output logic              ld_rdy,
  output logic              ld_ovf,
  input  logic              go,
  output logic              busy,
  output logic              Xin_val,
  output logic [IN_LEN-1:0] Xin_data,
  output logic              Yin_val,
  output logic [IN_LEN-1:0] Yin_data,
  output logic              SA_start
);

  localparam int c_x_depth = X * N;
  localparam int c_y_depth = Y * N;
  localparam int c_m       = max_depth(c_x_depth, c_y_depth);
  localparam int c_gap_w   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CNT_W-1:0]   c_x_len    = CNT_W'(c_x_depth);
  localparam logic [CNT_W-1:0]   c_y_len    = CNT_W'(c_y_depth);
  localparam logic [CNT_W-1:0]   c_idx_last = CNT_W'(c_m - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYC - 1);

  feed_state_t        r_state;
  feed_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_idx;
  logic [c_gap_w-1:0] r_gap;

  logic w_x_full;
  logic w_y_full;
  logic w_in_idle;
  logic w_go_ok;
  logic w_ld_x;
  logic w_ld_y;
  logic w_ovf_hit;
  logic w_clr;
  logic w_rd_x;
  logic w_rd_y;

  logic r_ld_rdy;
  logic r_ld_ovf;
  logic r_busy;
  logic r_x_val;
  logic r_y_val;
  logic r_sa_start;

  assign w_in_idle = (r_state == IDLE);
  assign w_go_ok   = w_in_idle && go && w_x_full && w_y_full;
  assign w_ld_x    = w_in_idle && ld_val && (ld_sel == SEL_X);
  assign w_ld_y    = w_in_idle && ld_val && (ld_sel == SEL_Y);
  assign w_ovf_hit = (w_ld_x && w_x_full) || (w_ld_y && w_y_full);
  assign w_clr     = (r_state == START);
  assign w_rd_x    = (r_state == STREAM) && (r_idx < c_x_len);
  assign w_rd_y    = (r_state == STREAM) && (r_idx < c_y_len);

  rsa_opnd_buf #(
    .DEPTH (c_x_depth),
    .WIDTH (IN_LEN),
    .CNT_W (CNT_W)
  ) u_xbuf (
    .clk       (clk),
    .rst       (sys_rst),
    .i_wr_en   (w_ld_x),
    .i_wr_data (ld_data),
    .i_clr     (w_clr),
    .i_rd_en   (w_rd_x),
    .i_rd_addr (r_idx),
    .o_rd_data (Xin_data),
    .o_full    (w_x_full)
  );

  rsa_opnd_buf #(
    .DEPTH (c_y_depth),
    .WIDTH (IN_LEN),
    .CNT_W (CNT_W)
  ) u_ybuf (
    .clk       (clk),
    .rst       (sys_rst),
    .i_wr_en   (w_ld_y),
    .i_wr_data (ld_data),
    .i_clr     (w_clr),
    .i_rd_en   (w_rd_y),
    .i_rd_addr (r_idx),
    .o_rd_data (Yin_data),
    .o_full    (w_y_full)
  );

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go_ok) w_state_nxt = STREAM;
      STREAM:  if (r_idx == c_idx_last) w_state_nxt = GAP;
      GAP:     if (r_gap == c_gap_last) w_state_nxt = START;
      START:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_idx <= '0;
      r_gap <= '0;
    end else begin
      r_idx <= (r_state == STREAM) ? r_idx + 1'b1 : '0;
      r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
    end
  end

  // Outputs lag the state by one edge, so each state's effect appears on its exit edge.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_ld_rdy   <= 1'b0;
      r_ld_ovf   <= 1'b0;
      r_busy     <= 1'b0;
      r_x_val    <= 1'b0;
      r_y_val    <= 1'b0;
      r_sa_start <= 1'b0;
    end else begin
      r_ld_rdy   <= (w_state_nxt == IDLE);
      r_ld_ovf   <= w_clr ? 1'b0 : (r_ld_ovf | w_ovf_hit);
      r_busy     <= !w_in_idle;
      r_x_val    <= w_rd_x;
      r_y_val    <= w_rd_y;
      r_sa_start <= (r_state == START);
    end
  end

  assign ld_rdy   = r_ld_rdy;
  assign ld_ovf   = r_ld_ovf;
  assign busy     = r_busy;
  assign Xin_val  = r_x_val;
  assign Yin_val  = r_y_val;
  assign SA_start = r_sa_start;

endmodule
`default_nettype wire

// File: tb/tb_rsa_operand_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rsa_operand_feeder : directed scoreboard bench for rsa_operand_feeder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rsa_operand_feeder;
  import rsa_feed_pkg::*;

  localparam int XD  = 12;
  localparam int YD  = 12;
  localparam int M   = 12;
  localparam int GAP = 1;
  localparam int LAST = M + GAP + 1;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ld_val = 1'b0;
  logic       ld_sel = 1'b0;
  logic [3:0] ld_data = 4'h0;
  logic       go = 1'b0;
  logic       ld_rdy, ld_ovf, busy, Xin_val, Yin_val, SA_start;
  logic [3:0] Xin_data, Yin_data;

  int checks = 0;
  int errors = 0;
  logic [3:0] xq[$];
  logic [3:0] yq[$];
  logic       m_ovf = 1'b0;

  rsa_operand_feeder #(
    .X(3), .N(4), .Y(3), .IN_LEN(4), .CNT_W(4), .GAP_CYC(GAP)
  ) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .ld_val   (ld_val),
    .ld_sel   (ld_sel),
    .ld_data  (ld_data),
    .ld_rdy   (ld_rdy),
    .ld_ovf   (ld_ovf),
    .go       (go),
    .busy     (busy),
    .Xin_val  (Xin_val),
    .Xin_data (Xin_data),
    .Yin_val  (Yin_val),
    .Yin_data (Yin_data),
    .SA_start (SA_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [3:0] d);
    ld_val = 1'b1; ld_sel = sel; ld_data = d;
    step();
    ld_val = 1'b0;
    if (sel == SEL_X) begin
      if (xq.size() < XD) xq.push_back(d); else m_ovf = 1'b1;
    end else begin
      if (yq.size() < YD) yq.push_back(d); else m_ovf = 1'b1;
    end
  endtask

  task automatic load_all(input int sx, input int sy);
    for (int i = 0; i < XD; i++) load(SEL_X, 4'((sx + 5 * i) & 15));
    for (int i = 0; i < YD; i++) load(SEL_Y, 4'((sy + 3 * i) & 15));
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_xval"}, 32'(Xin_val), 32'(0));
    chk({tag, "_yval"}, 32'(Yin_val), 32'(0));
    chk({tag, "_sa"}, 32'(SA_start), 32'(0));
  endtask

  // Called right after the go edge k; walks edges k+1..k+last_t.
  task automatic expect_stream(input bit inject, input int last_t);
    logic [3:0] ex, ey;
    for (int t = 1; t <= last_t; t++) begin
      if (inject && t == 5) begin
        go = 1'b1; ld_val = 1'b1; ld_sel = SEL_X; ld_data = 4'h5;
      end
      step();
      go = 1'b0; ld_val = 1'b0;
      chk("busy", 32'(busy), 32'(t <= LAST));
      chk("sa_start", 32'(SA_start), 32'(t == LAST));
      chk("ld_rdy", 32'(ld_rdy), 32'(t >= LAST));
      chk("ld_ovf", 32'(ld_ovf), 32'((t < LAST) ? m_ovf : 1'b0));
      if (t <= XD) begin
        ex = (xq.size() > 0) ? xq.pop_front() : 4'h0;
        chk("xval", 32'(Xin_val), 32'(1));
        chk("xdata", 32'(Xin_data), 32'(ex));
      end else begin
        chk("xval_idle", 32'(Xin_val), 32'(0));
        chk("xdata_idle", 32'(Xin_data), 32'(0));
      end
      if (t <= YD) begin
        ey = (yq.size() > 0) ? yq.pop_front() : 4'h0;
        chk("yval", 32'(Yin_val), 32'(1));
        chk("ydata", 32'(Yin_data), 32'(ey));
      end else begin
        chk("yval_idle", 32'(Yin_val), 32'(0));
        chk("ydata_idle", 32'(Yin_data), 32'(0));
      end
    end
    if (last_t >= LAST) m_ovf = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_quiet("rst");
    chk("rst_ld_rdy", 32'(ld_rdy), 32'(0));
    chk("rst_ld_ovf", 32'(ld_ovf), 32'(0));
    sys_rst = 1'b0;
    step();
    chk("rdy_after_rst", 32'(ld_rdy), 32'(1));

    // 1: ascending X, descending Y
    for (int i = 0; i < XD; i++) load(SEL_X, 4'(i + 1));
    for (int i = 0; i < YD; i++) load(SEL_Y, 4'(15 - i));
    pulse_go();
    chk("go_edge_busy", 32'(busy), 32'(0));
    expect_stream(1'b0, LAST + 1);

    // 2: X one short, go ignored; completing X then go streams
    for (int i = 0; i < XD - 1; i++) load(SEL_X, 4'((2 + 5 * i) & 15));
    for (int i = 0; i < YD; i++) load(SEL_Y, 4'((7 + 3 * i) & 15));
    pulse_go();
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("short_x");
    end
    load(SEL_X, 4'h9);
    pulse_go();
    expect_stream(1'b0, LAST + 1);

    // 3: overflow on full X buffer
    load_all(4, 1);
    chk("ovf_before", 32'(ld_ovf), 32'(0));
    load(SEL_X, 4'hE);
    chk("ovf_set", 32'(ld_ovf), 32'(1));
    pulse_go();
    expect_stream(1'b0, LAST + 1);
    chk("ovf_cleared", 32'(ld_ovf), 32'(0));

    // 4: go coincident with the final Y load is ignored
    for (int i = 0; i < XD; i++) load(SEL_X, 4'((11 + 7 * i) & 15));
    for (int i = 0; i < YD - 1; i++) load(SEL_Y, 4'((3 + 5 * i) & 15));
    go = 1'b1;
    load(SEL_Y, 4'hA);
    go = 1'b0;
    check_quiet("go_with_load");
    pulse_go();
    chk("late_go_edge_busy", 32'(busy), 32'(0));
    expect_stream(1'b0, LAST + 1);

    // 5: go and a load mid-stream have no effect
    load_all(6, 13);
    pulse_go();
    expect_stream(1'b1, LAST + 1);

    // 6: reset at stream word 5
    load_all(0, 9);
    pulse_go();
    expect_stream(1'b0, 5);
    sys_rst = 1'b1;
    step();
    check_quiet("midrst");
    chk("midrst_ld_rdy", 32'(ld_rdy), 32'(0));
    chk("midrst_ld_ovf", 32'(ld_ovf), 32'(0));
    chk("midrst_xdata", 32'(Xin_data), 32'(0));
    chk("midrst_ydata", 32'(Yin_data), 32'(0));
    sys_rst = 1'b0;
    xq.delete();
    yq.delete();
    m_ovf = 1'b0;
    step();
    chk("rdy_after_midrst", 32'(ld_rdy), 32'(1));
    pulse_go();
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("go_after_rst");
    end
    load_all(8, 2);
    pulse_go();
    expect_stream(1'b0, LAST + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
